// File: rtl/lfsr_run_sched_pkg.sv
// Shared types and constants for the LFSR run scheduler and its datapath.
package lfsr_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam logic [3:0]  TAP_DEFAULT = 4'b0111;
   localparam int unsigned NUM_CLIENTS = 32'd2;
   localparam int unsigned MAX_WIDTH   = 32'd16;

   // Parity of a tapped register image, zero-extended to the widest legal LFSR.
   function automatic logic tap_parity(input logic [MAX_WIDTH-1:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/lfsr_run_sched_core.sv
// Fibonacci LFSR register: load, feedback step or plain right shift.
module lfsr_core
   import lfsr_pkg::*;
#(
   parameter int unsigned      WIDTH    = 32'd4,
   parameter logic [WIDTH-1:0] TAP_MASK = WIDTH'(TAP_DEFAULT)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             step,
   input  logic             shr,
   output logic [WIDTH-1:0] r
);

   logic [WIDTH-1:0] r_r;
   logic [WIDTH-1:0] r_nxt_s;
   logic             fb_s;

   // Next register value; load wins, feedback enters at the MSB.
   always_comb begin
      fb_s = tap_parity(MAX_WIDTH'(r_r & TAP_MASK));
      if (load) begin
         r_nxt_s = load_val;
      end else if (step) begin
         r_nxt_s = {fb_s, r_r[WIDTH-1:1]};
      end else if (shr) begin
         r_nxt_s = {1'b0, r_r[WIDTH-1:1]};
      end else begin
         r_nxt_s = r_r;
      end
   end

   // Register update with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_r <= {WIDTH{1'b0}};
      end else begin
         r_r <= r_nxt_s;
      end
   end

   assign r = r_r;

endmodule

// File: rtl/lfsr_run_sched.sv
// Two-client round-robin scheduler sharing one LFSR: seed load, run, LSB-first serialize.
module lfsr_run_sched
   import lfsr_pkg::*;
#(
   parameter int unsigned      WIDTH      = 32'd4,
   parameter int unsigned      RUN_CYCLES = 32'd8,
   parameter logic [WIDTH-1:0] TAP_MASK   = WIDTH'(TAP_DEFAULT)
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [NUM_CLIENTS-1:0] req,
   input  logic [WIDTH-1:0]       seed0,
   input  logic [WIDTH-1:0]       seed1,
   input  logic                   abort,
   output logic [NUM_CLIENTS-1:0] gnt,
   output logic                   busy,
   output logic                   out_valid,
   output logic                   out_bit,
   output logic                   out_id,
   output logic                   done
);

   localparam int unsigned STEP_W = (RUN_CYCLES > 32'd0) ? $clog2(RUN_CYCLES + 32'd1) : 32'd1;
   localparam int unsigned BIT_W  = $clog2(WIDTH + 32'd1);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'((RUN_CYCLES == 32'd0) ? 32'd0 : RUN_CYCLES - 32'd1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 32'd1);
   localparam logic [WIDTH-1:0]  SEED_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam bit                NO_RUN    = (RUN_CYCLES == 32'd0);

   state_e                 state_r, state_nxt_s;
   logic [STEP_W-1:0]      step_cnt_r, step_cnt_nxt_s;
   logic [BIT_W-1:0]       bit_cnt_r, bit_cnt_nxt_s;
   logic                   ptr_r, ptr_nxt_s;
   logic                   winner_s;
   logic                   accept_s;
   logic [WIDTH-1:0]       seed_sel_s;
   logic [WIDTH-1:0]       load_val_s;
   logic [WIDTH-1:0]       r_s;
   logic                   load_s, step_s, shr_s;

   logic [NUM_CLIENTS-1:0] gnt_r, gnt_nxt_s;
   logic                   busy_r, busy_nxt_s;
   logic                   out_valid_r, out_valid_nxt_s;
   logic                   out_bit_r, out_bit_nxt_s;
   logic                   out_id_r, out_id_nxt_s;
   logic                   done_r, done_nxt_s;

   lfsr_core #(
      .WIDTH    (WIDTH),
      .TAP_MASK (TAP_MASK)
   ) u_core (
      .CLK      (CLK),
      .RST      (RST),
      .load     (load_s),
      .load_val (load_val_s),
      .step     (step_s),
      .shr      (shr_s),
      .r        (r_s)
   );

   // State register.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state, arbitration and counter/pointer updates.
   always_comb begin
      state_nxt_s    = state_r;
      step_cnt_nxt_s = step_cnt_r;
      bit_cnt_nxt_s  = bit_cnt_r;
      ptr_nxt_s      = ptr_r;
      accept_s       = 1'b0;
      case (req)
         2'b01:   winner_s = 1'b0;
         2'b10:   winner_s = 1'b1;
         default: winner_s = ptr_r;
      endcase
      case (state_r)
         IDLE: begin
            if ((req != 2'b00) && !abort) begin
               accept_s       = 1'b1;
               ptr_nxt_s      = ~winner_s;
               step_cnt_nxt_s = {STEP_W{1'b0}};
               bit_cnt_nxt_s  = {BIT_W{1'b0}};
               state_nxt_s    = NO_RUN ? SHIFT : RUN;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RUN: begin
            if (abort) begin
               state_nxt_s = IDLE;
            end else if (step_cnt_r == STEP_LAST) begin
               state_nxt_s   = SHIFT;
               bit_cnt_nxt_s = {BIT_W{1'b0}};
            end else begin
               step_cnt_nxt_s = step_cnt_r + 1'b1;
            end
         end
         SHIFT: begin
            if (abort) begin
               state_nxt_s = IDLE;
            end else if (bit_cnt_r == BIT_LAST) begin
               state_nxt_s = DONE;
            end else begin
               bit_cnt_nxt_s = bit_cnt_r + 1'b1;
            end
         end
         DONE:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Datapath control and next values of the registered outputs.
   always_comb begin
      seed_sel_s = winner_s ? seed1 : seed0;
      load_val_s = (seed_sel_s == {WIDTH{1'b0}}) ? SEED_ONE : seed_sel_s;
      load_s     = accept_s;
      step_s     = (state_r == RUN) && !abort;
      shr_s      = (state_r == SHIFT) && !abort;

      gnt_nxt_s       = accept_s ? (winner_s ? 2'b10 : 2'b01) : 2'b00;
      busy_nxt_s      = (state_nxt_s != IDLE);
      out_valid_nxt_s = (state_nxt_s == SHIFT);
      out_id_nxt_s    = accept_s ? winner_s : out_id_r;
      done_nxt_s      = (state_nxt_s == DONE);
      // Both a feedback step and a plain shift move R[1] into the LSB.
      if (!out_valid_nxt_s) begin
         out_bit_nxt_s = 1'b0;
      end else if (accept_s) begin
         out_bit_nxt_s = load_val_s[0];
      end else begin
         out_bit_nxt_s = 1'(r_s >> 1);
      end
   end

   // Counters, priority pointer and output registers.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         step_cnt_r  <= {STEP_W{1'b0}};
         bit_cnt_r   <= {BIT_W{1'b0}};
         ptr_r       <= 1'b0;
         gnt_r       <= 2'b00;
         busy_r      <= 1'b0;
         out_valid_r <= 1'b0;
         out_bit_r   <= 1'b0;
         out_id_r    <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         step_cnt_r  <= step_cnt_nxt_s;
         bit_cnt_r   <= bit_cnt_nxt_s;
         ptr_r       <= ptr_nxt_s;
         gnt_r       <= gnt_nxt_s;
         busy_r      <= busy_nxt_s;
         out_valid_r <= out_valid_nxt_s;
         out_bit_r   <= out_bit_nxt_s;
         out_id_r    <= out_id_nxt_s;
         done_r      <= done_nxt_s;
      end
   end

   assign gnt       = gnt_r;
   assign busy      = busy_r;
   assign out_valid = out_valid_r;
   assign out_bit   = out_bit_r;
   assign out_id    = out_id_r;
   assign done      = done_r;

endmodule

// File: tb/tb_lfsr_run_sched.sv
// Bench for lfsr_run_sched: default and RUN_CYCLES=0 instances against a job-timeline model.
module tb_lfsr_run_sched;

   localparam int W   = 4;
   localparam int RC0 = 8;
   localparam int RC1 = 0;

   logic CLK = 1'b0;
   logic RST;
   logic [1:0][1:0]   req_a;
   logic [1:0][W-1:0] seed0_a, seed1_a;
   logic [1:0]        abort_a;
   logic [1:0][1:0]   gnt_a;
   logic [1:0]        busy_a, ov_a, ob_a, oid_a, done_a;

   int checks = 0, failures = 0, cyc = 0;
   bit auto_drop;
   logic [W-1:0] cap [2];
   int ndone [2], done_cyc [2];
   int gid0[$], gid1[$], gcyc0[$], gcyc1[$];

   bit m_act [2], m_id [2], m_ptr [2];
   int m_k [2];
   logic [W-1:0] m_post [2];

   always #5 CLK = ~CLK;

   lfsr_run_sched #(.WIDTH(W), .RUN_CYCLES(RC0), .TAP_MASK(4'b0111)) u_dut0 (
      .CLK(CLK), .RST(RST), .req(req_a[0]), .seed0(seed0_a[0]), .seed1(seed1_a[0]), .abort(abort_a[0]),
      .gnt(gnt_a[0]), .busy(busy_a[0]), .out_valid(ov_a[0]), .out_bit(ob_a[0]), .out_id(oid_a[0]), .done(done_a[0]));

   lfsr_run_sched #(.WIDTH(W), .RUN_CYCLES(RC1), .TAP_MASK(4'b0111)) u_dut1 (
      .CLK(CLK), .RST(RST), .req(req_a[1]), .seed0(seed0_a[1]), .seed1(seed1_a[1]), .abort(abort_a[1]),
      .gnt(gnt_a[1]), .busy(busy_a[1]), .out_valid(ov_a[1]), .out_bit(ob_a[1]), .out_id(oid_a[1]), .done(done_a[1]));

   function automatic int runc(input int d);
      return (d == 0) ? RC0 : RC1;
   endfunction

   // Reference LFSR: n feedback steps with taps 0111, feedback into the MSB.
   function automatic logic [W-1:0] lfsr_after(input logic [W-1:0] s, input int n);
      int v = int'(s);
      for (int i = 0; i < n; i++) begin
         int fb = ((v & 7) == 1 || (v & 7) == 2 || (v & 7) == 4 || (v & 7) == 7) ? 1 : 0;
         v = (v >> 1) | (fb << (W - 1));
      end
      return W'(v);
   endfunction

   task automatic check_eq(input string tag, input int d, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s dut%0d cyc=%0d got=%0h exp=%0h", tag, d, cyc, got, exp);
      end
   endtask

   // Advance the model across one rising edge using the inputs currently applied.
   task automatic model_edge();
      for (int d = 0; d < 2; d++) begin
         if (!RST) begin
            m_act[d] = 1'b0; m_ptr[d] = 1'b0; m_id[d] = 1'b0;
         end else if (m_act[d]) begin
            if (abort_a[d] || m_k[d] == runc(d) + W + 1) m_act[d] = 1'b0;
            else m_k[d]++;
         end else if (req_a[d] != 2'b00 && !abort_a[d]) begin
            bit w;
            logic [W-1:0] s;
            w = (req_a[d] == 2'b11) ? m_ptr[d] : req_a[d][1];
            s = w ? seed1_a[d] : seed0_a[d];
            if (s == '0) s = W'(1);
            m_post[d] = lfsr_after(s, runc(d));
            m_act[d] = 1'b1; m_k[d] = 1; m_id[d] = w; m_ptr[d] = !w;
         end
      end
   endtask

   task automatic check_outputs();
      for (int d = 0; d < 2; d++) begin
         int rc = runc(d);
         int k = m_k[d];
         logic [1:0] e_gnt = (m_act[d] && k == 1) ? (m_id[d] ? 2'b10 : 2'b01) : 2'b00;
         bit e_ov = m_act[d] && k >= rc + 1 && k <= rc + W;
         bit e_done = m_act[d] && k == rc + W + 1;
         check_eq("gnt", d, 32'(gnt_a[d]), 32'(e_gnt));
         check_eq("busy", d, 32'(busy_a[d]), 32'(m_act[d]));
         check_eq("out_valid", d, 32'(ov_a[d]), 32'(e_ov));
         check_eq("done", d, 32'(done_a[d]), 32'(e_done));
         check_eq("out_id", d, 32'(oid_a[d]), 32'(m_id[d]));
         if (e_ov) check_eq("out_bit", d, 32'(ob_a[d]), 32'(m_post[d][k - rc - 1]));
         if (ov_a[d] === 1'b1) cap[d] = {ob_a[d], cap[d][W-1:1]};
         if (done_a[d] === 1'b1) begin ndone[d]++; done_cyc[d] = cyc; end
         if (gnt_a[d] != 2'b00) begin
            if (d == 0) begin gid0.push_back(int'(gnt_a[d][1])); gcyc0.push_back(cyc); end
            else begin gid1.push_back(int'(gnt_a[d][1])); gcyc1.push_back(cyc); end
         end
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      model_edge();
      @(negedge CLK);
      cyc++;
      check_outputs();
      if (auto_drop) for (int d = 0; d < 2; d++) req_a[d] = req_a[d] & ~gnt_a[d];
   endtask

   task automatic clear_obs();
      cyc = 0;
      for (int d = 0; d < 2; d++) begin cap[d] = '0; ndone[d] = 0; done_cyc[d] = -1; end
      gid0.delete(); gid1.delete(); gcyc0.delete(); gcyc1.delete();
   endtask

   task automatic do_reset();
      req_a = '0; abort_a = '0; RST = 1'b0;
      repeat (2) tick();
      RST = 1'b1;
   endtask

   // Single client-0 job with seed 1001 on both instances.
   task automatic single_job(input bit with_reset);
      if (with_reset) do_reset();
      auto_drop = 1'b1;
      seed0_a = {4'b1001, 4'b1001};
      req_a = {2'b01, 2'b01};
      clear_obs();
      repeat (16) tick();
      check_eq("s1_stream", 0, 32'(cap[0]), 32'h0000000C);
      check_eq("s1_stream", 1, 32'(cap[1]), 32'h00000009);
      check_eq("s1_done_cyc", 0, 32'(done_cyc[0]), 32'd13);
      check_eq("s1_done_cyc", 1, 32'(done_cyc[1]), 32'd5);
      check_eq("s1_ndone", 0, 32'(ndone[0]), 32'd1);
      check_eq("s1_gnt_cyc", 0, (gcyc0.size() > 0) ? 32'(gcyc0[0]) : 32'hFFFFFFFF, 32'd1);
   endtask

   initial begin
      RST = 1'b0; req_a = '0; abort_a = '0; seed0_a = '0; seed1_a = '0; auto_drop = 1'b0;
      for (int d = 0; d < 2; d++) begin m_act[d] = 1'b0; m_id[d] = 1'b0; m_ptr[d] = 1'b0; m_k[d] = 0; end
      clear_obs();
      repeat (2) tick();
      for (int d = 0; d < 2; d++) begin
         check_eq("rst_gnt", d, 32'(gnt_a[d]), 32'd0);
         check_eq("rst_id", d, 32'(oid_a[d]), 32'd0);
      end
      RST = 1'b1;

      single_job(1'b1);

      // Contention: both clients held, grants must alternate.
      do_reset();
      auto_drop = 1'b0;
      seed0_a = {4'b1001, 4'b1001}; seed1_a = {4'b0011, 4'b0011};
      req_a = {2'b11, 2'b11};
      clear_obs();
      repeat (45) tick();
      check_eq("rr_count", 0, 32'(gid0.size() >= 3), 32'd1);
      check_eq("rr_count", 1, 32'(gid1.size() >= 3), 32'd1);
      if (gid0.size() >= 3) check_eq("rr_order", 0, 32'({gid0[0][0], gid0[1][0], gid0[2][0]}), 32'b010);
      if (gid1.size() >= 3) check_eq("rr_order", 1, 32'({gid1[0][0], gid1[1][0], gid1[2][0]}), 32'b010);

      // Zero seed on client 1 is run as 0001.
      do_reset();
      auto_drop = 1'b1;
      seed1_a = '0;
      req_a = {2'b10, 2'b10};
      clear_obs();
      repeat (16) tick();
      check_eq("zero_seed_stream", 0, 32'(cap[0]), 32'h00000008);
      check_eq("zero_seed_stream", 1, 32'(cap[1]), 32'h00000001);

      // Abort after two serialized bits; held request is re-granted.
      do_reset();
      auto_drop = 1'b0;
      seed1_a = {4'b0011, 4'b0011};
      req_a = {2'b10, 2'b10};
      clear_obs();
      repeat (14) begin
         abort_a[0] = (cyc == 10);
         tick();
         if (cyc == 11) begin
            check_eq("abort_busy", 0, 32'(busy_a[0]), 32'd0);
            check_eq("abort_valid", 0, 32'(ov_a[0]), 32'd0);
         end
      end
      abort_a = '0;
      check_eq("abort_ndone", 0, 32'(ndone[0]), 32'd0);
      check_eq("abort_regnt", 0, (gcyc0.size() > 1) ? 32'(gcyc0[1]) : 32'hFFFFFFFF, 32'd12);
      check_eq("abort_regnt_id", 0, (gid0.size() > 1) ? 32'(gid0[1]) : 32'hFFFFFFFF, 32'd1);

      // Reset in the middle of a run, then replay the single job.
      do_reset();
      auto_drop = 1'b1;
      seed0_a = {4'b1001, 4'b1001};
      req_a = {2'b01, 2'b01};
      repeat (4) tick();
      RST = 1'b0;
      tick();
      check_eq("midrst_busy", 0, 32'(busy_a[0]), 32'd0);
      check_eq("midrst_id", 0, 32'(oid_a[0]), 32'd0);
      RST = 1'b1;
      single_job(1'b0);

      // Randomized traffic with clients that hold req until granted.
      auto_drop = 1'b0;
      repeat (1500) begin
         RST = ($urandom_range(0, 199) != 0);
         for (int d = 0; d < 2; d++) begin
            abort_a[d] = ($urandom_range(0, 39) == 0);
            for (int c = 0; c < 2; c++) begin
               if (req_a[d][c] && gnt_a[d][c]) begin
                  req_a[d][c] = 1'b0;
               end else if (!req_a[d][c] && $urandom_range(0, 3) == 0) begin
                  req_a[d][c] = 1'b1;
                  if (c == 0) seed0_a[d] = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
                  else        seed1_a[d] = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
               end
            end
         end
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
